mips_sequencer: RTL and testbench

- Multi-cycle control FSM for the MIPS core. It replaces free-running divided clocks with per-stage enable strobes on the single core clock.
- It walks each instruction through fetch, decode, execute, memory and writeback, and handshakes with the shared instruction/data memory via request/ready.
- It drives the PC, instruction-register, register-file, ALU-source and memory-select controls, and counts retired instructions.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/mips_sequencer_instr_classifier.sv | 24 ++
 rtl/mips_sequencer.sv | 144 ++++++++++++++
 tb/tb_mips_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared states, instruction classes and encodings for the MIPS sequencer
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } state_t;

  // NOP is the idle value of the latched class and what a tolerated illegal opcode becomes
  typedef enum logic [3:0] {
    NOP,
    RTYPE,
    IALU,
    LOAD,
    STORE,
    BRANCH_EQ,
    BRANCH_NE,
    JUMP,
    SYSCALL,
    ILLEGAL
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNC_SYSCALL = 6'h0C;

  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_sequencer_instr_classifier.sv
// rtl/mips_sequencer_instr_classifier.sv - combinational opcode/func to instruction class
module instr_classifier
  import mips_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   func,
  output instr_class_t instr_class
);

  always_comb begin
    instr_class = ILLEGAL;
    case (opcode)
      OP_RTYPE: instr_class = (func == FUNC_SYSCALL) ? SYSCALL : RTYPE;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: instr_class = IALU;
      OP_LW:  instr_class = LOAD;
      OP_SW:  instr_class = STORE;
      OP_BEQ: instr_class = BRANCH_EQ;
      OP_BNE: instr_class = BRANCH_NE;
      OP_J:   instr_class = JUMP;
      default: instr_class = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_sequencer.sv
// rtl/mips_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control FSM
module mips_sequencer
  import mips_pkg::*;
#(
  parameter int RETIRE_WIDTH    = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic [5:0]              opcode,
  input  logic [5:0]              func,
  input  logic                    alu_zero,
  input  logic                    mem_ready,
  output logic                    mem_request,
  output logic                    mem_write,
  output logic                    mem_select_data,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic [1:0]              pc_source,
  output logic                    alu_src_imm,
  output logic                    reg_write,
  output logic                    reg_dest_rd,
  output logic                    reg_src_mem,
  output logic [2:0]              state,
  output logic [RETIRE_WIDTH-1:0] retired,
  output logic                    illegal
);

  localparam logic [RETIRE_WIDTH-1:0] RETIRE_ONE = RETIRE_WIDTH'(1);

  state_t       state_q, state_d;
  instr_class_t cls_q, dec_class, cls;
  logic         retire_now;

  instr_classifier u_classifier (
    .opcode      (opcode),
    .func        (func),
    .instr_class (dec_class)
  );

  // In DECODE the class is not latched yet, so the jump strobes come straight from the classifier
  assign cls   = (state_q == DECODE) ? dec_class : cls_q;
  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    retire_now = 1'b0;
    case (state_q)
      IDLE:  if (run) state_d = FETCH;
      FETCH: if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (dec_class)
          SYSCALL: state_d = HALT;
          JUMP:    retire_now = 1'b1;
          ILLEGAL: begin
            if (HALT_ON_ILLEGAL) state_d = HALT;
            else retire_now = 1'b1;
          end
          default: state_d = EXECUTE;
        endcase
      end
      EXECUTE: begin
        case (cls_q)
          BRANCH_EQ, BRANCH_NE: retire_now = 1'b1;
          LOAD, STORE:          state_d = MEMORY;
          default:              state_d = WRITEBACK;
        endcase
      end
      MEMORY: begin
        if (mem_ready) begin
          if (cls_q == STORE) retire_now = 1'b1;
          else state_d = WRITEBACK;
        end
      end
      WRITEBACK: retire_now = 1'b1;
      HALT:      state_d = HALT;
      default:   state_d = IDLE;
    endcase
    if (retire_now) state_d = run ? FETCH : IDLE;
  end

  always_comb begin
    mem_request     = 1'b0;
    mem_write       = 1'b0;
    mem_select_data = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_source       = PC_SRC_INC;
    alu_src_imm     = 1'b0;
    reg_write       = 1'b0;
    reg_dest_rd     = 1'b0;
    reg_src_mem     = 1'b0;
    case (state_q)
      FETCH: begin
        mem_request = 1'b1;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
      end
      DECODE: begin
        if (cls == JUMP) begin
          pc_write  = 1'b1;
          pc_source = PC_SRC_JUMP;
        end
      end
      EXECUTE: begin
        alu_src_imm = (cls == IALU) || (cls == LOAD) || (cls == STORE);
        if (cls == BRANCH_EQ || cls == BRANCH_NE) begin
          pc_source = PC_SRC_BRANCH;
          pc_write  = (cls == BRANCH_EQ) ? alu_zero : !alu_zero;
        end
      end
      MEMORY: begin
        mem_request     = 1'b1;
        mem_select_data = 1'b1;
        mem_write       = (cls == STORE);
        alu_src_imm     = 1'b1;
      end
      WRITEBACK: begin
        reg_write   = 1'b1;
        reg_dest_rd = (cls == RTYPE);
        reg_src_mem = (cls == LOAD);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cls_q   <= NOP;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        cls_q <= (dec_class == ILLEGAL) ? NOP : dec_class;
        if (dec_class == ILLEGAL) illegal <= 1'b1;
      end
      if (retire_now) retired <= retired + RETIRE_ONE;
    end
  end

endmodule

// File: tb/tb_mips_sequencer.sv
// tb/tb_mips_sequencer.sv - directed self-checking bench for mips_sequencer
module tb_mips_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] func = 6'h00;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_request, mem_write, mem_select_data, ir_write, pc_write;
  logic [1:0] pc_source;
  logic       alu_src_imm, reg_write, reg_dest_rd, reg_src_mem, illegal;
  logic [2:0] state;
  logic [3:0] retired;

  logic       n_mem_request, n_mem_write, n_mem_select_data, n_ir_write, n_pc_write;
  logic [1:0] n_pc_source;
  logic       n_alu_src_imm, n_reg_write, n_reg_dest_rd, n_reg_src_mem, n_illegal;
  logic [2:0] n_state;
  logic [3:0] n_retired;

  int checks = 0;
  int failures = 0;
  int bad;

  always #5 clock = ~clock;

  mips_sequencer #(.RETIRE_WIDTH(4), .HALT_ON_ILLEGAL(1'b1)) u_dut (
    .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .func(func),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_request(mem_request),
    .mem_write(mem_write), .mem_select_data(mem_select_data), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_imm(alu_src_imm),
    .reg_write(reg_write), .reg_dest_rd(reg_dest_rd), .reg_src_mem(reg_src_mem),
    .state(state), .retired(retired), .illegal(illegal)
  );

  mips_sequencer #(.RETIRE_WIDTH(4), .HALT_ON_ILLEGAL(1'b0)) u_nop (
    .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .func(func),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_request(n_mem_request),
    .mem_write(n_mem_write), .mem_select_data(n_mem_select_data), .ir_write(n_ir_write),
    .pc_write(n_pc_write), .pc_source(n_pc_source), .alu_src_imm(n_alu_src_imm),
    .reg_write(n_reg_write), .reg_dest_rd(n_reg_dest_rd), .reg_src_mem(n_reg_src_mem),
    .state(n_state), .retired(n_retired), .illegal(n_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic any_strobe();
    return mem_request | mem_write | mem_select_data | ir_write | pc_write | (|pc_source) |
           alu_src_imm | reg_write | reg_dest_rd | reg_src_mem;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_strobes", 32'(any_strobe()), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_hold", 32'(state), 32'd0);

    // R-type add: FETCH, DECODE, EXECUTE, WRITEBACK
    run = 1'b1; mem_ready = 1'b1; opcode = 6'h00; func = 6'h20;
    tick();
    chk("r_fetch", 32'(state), 32'd1);
    chk("r_fetch_ir", 32'({mem_request, ir_write, pc_write, mem_select_data}), 32'b1110);
    tick();
    chk("r_decode", 32'(state), 32'd2);
    chk("r_decode_rw", 32'(reg_write), 32'd0);
    tick();
    chk("r_execute", 32'(state), 32'd3);
    chk("r_exec_imm", 32'(alu_src_imm), 32'd0);
    tick();
    chk("r_wb", 32'(state), 32'd5);
    chk("r_wb_strobes", 32'({reg_write, reg_dest_rd, reg_src_mem}), 32'b110);
    run = 1'b0;
    tick();
    chk("r_idle", 32'(state), 32'd0);
    chk("r_retired", 32'(retired), 32'd1);
    chk("r_rw_off", 32'(reg_write), 32'd0);

    // LW with three wait cycles in MEMORY
    run = 1'b1; opcode = 6'h23; func = 6'h00;
    tick(); tick(); tick();
    chk("lw_execute", 32'(state), 32'd3);
    chk("lw_exec_imm", 32'(alu_src_imm), 32'd1);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("lw_mem_state", 32'(state), 32'd4);
      chk("lw_mem_strobes", 32'({mem_request, mem_select_data, mem_write, alu_src_imm}), 32'b1101);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    chk("lw_wb", 32'(state), 32'd5);
    chk("lw_wb_strobes", 32'({reg_write, reg_dest_rd, reg_src_mem}), 32'b101);
    run = 1'b0;
    tick();
    chk("lw_retired", 32'(retired), 32'd2);

    // BEQ taken, then BEQ not taken back to back
    run = 1'b1; opcode = 6'h04; alu_zero = 1'b1;
    tick(); tick(); tick();
    chk("beq1_state", 32'(state), 32'd3);
    chk("beq1_pc", 32'({pc_write, pc_source, alu_src_imm}), 32'b1010);
    alu_zero = 1'b0;
    tick();
    chk("beq1_next_fetch", 32'(state), 32'd1);
    chk("beq1_retired", 32'(retired), 32'd3);
    tick(); tick();
    chk("beq2_pc", 32'({pc_write, pc_source}), 32'b001);
    run = 1'b0;
    tick();
    chk("beq2_retired", 32'(retired), 32'd4);

    // BNE with alu_zero=0 takes the branch
    run = 1'b1; opcode = 6'h05;
    tick(); tick(); tick();
    chk("bne_pc", 32'({pc_write, pc_source}), 32'b101);
    run = 1'b0;
    tick();
    chk("bne_retired", 32'(retired), 32'd5);

    // J retires from DECODE
    run = 1'b1; opcode = 6'h02;
    tick(); tick();
    chk("j_decode_pc", 32'({state, pc_write, pc_source}), {26'd0, 3'd2, 1'b1, 2'd2});
    run = 1'b0;
    tick();
    chk("j_retired", 32'({state, retired}), {25'd0, 3'd0, 4'd6});

    // SW with run dropped mid-instruction: store completes, then idle
    run = 1'b1; opcode = 6'h2B;
    tick();
    run = 1'b0;
    tick(); tick();
    chk("sw_exec_imm", 32'(alu_src_imm), 32'd1);
    tick();
    chk("sw_mem", 32'({state, mem_request, mem_select_data, mem_write}), {25'd0, 3'd4, 3'b111});
    tick();
    chk("sw_idle", 32'({state, retired}), {25'd0, 3'd0, 4'd7});
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_request) bad++;
    end
    chk("sw_no_req", 32'(bad), 32'd0);

    // Illegal opcode: halting build halts, tolerant build retires
    run = 1'b1; opcode = 6'h3F;
    tick(); tick(); tick();
    chk("ill_halt", 32'({state, illegal}), {28'd0, 3'd6, 1'b1});
    chk("ill_retired", 32'(retired), 32'd7);
    chk("nop_build", 32'({n_state, n_illegal, n_retired}), {24'd0, 3'd1, 1'b1, 4'd8});
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (any_strobe() || state != 3'd6) bad++;
    end
    chk("halt_quiet", 32'(bad), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("halt_reset", 32'({state, illegal, retired}), 32'd0);
    run = 1'b0;
    tick();
    reset_n = 1'b1;

    // Asynchronous reset during a FETCH wait drops the request immediately
    run = 1'b1; opcode = 6'h00; func = 6'h20; mem_ready = 1'b0;
    tick(); tick();
    chk("fw_req", 32'({state, mem_request}), {28'd0, 3'd1, 1'b1});
    #2;
    reset_n = 1'b0;
    #1;
    chk("fw_reset", 32'({state, mem_request}), 32'd0);
    tick();
    reset_n = 1'b1;

    // Retired counter wraps after 16 back-to-back jumps
    opcode = 6'h02; mem_ready = 1'b1; run = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick(); tick();
    end
    chk("wrap_ones", 32'(retired), 32'd15);
    tick(); tick();
    chk("wrap_zero", 32'(retired), 32'd0);
    run = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
